// File: rtl/wb_prio_enc_pkg.sv
// Shared definitions for the Wishbone front-end of the 8-to-3 priority encoder:
// register offsets, CTRL/STATUS/RESULT bit positions, sequencer states, result entry.
package wb_prio_enc_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_REQ    = 2'd1;
    localparam logic [1:0] REG_RESULT = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_OVF  = 8;
    localparam int STAT_BUSY = 9;

    localparam int RES_ENO   = 8;
    localparam int RES_GS    = 9;
    localparam int RES_VALID = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       gs;
        logic       eno;
        logic [2:0] code;
    } result_t;

endpackage

// File: rtl/prio_enc_fifo.sv
// Synchronous FIFO with flush; a push into a full queue is accepted only when a pop
// frees a slot in the same cycle. DEPTH must be a power of two so pointers wrap freely.
module prio_enc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; entries are only observable once counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_prio_enc_ctrl.sv
// Wishbone classic slave queueing request vectors to the priority encoder and results back.
// Define PRIO_ENC_IRQ_EN to implement CTRL.irq_en and the result-available interrupt.
module wb_prio_enc_ctrl
    import wb_prio_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          ENC_WAIT   = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  enc_in,
    output logic        enc_en,
    input  logic [2:0]  enc_code,
    input  logic        enc_gs,
    input  logic        enc_eno,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t  state;
    logic [2:0]  wait_cnt;
    logic        enable;
    logic        irq_en;
    logic        ovf;

    logic        addr_hit;
    logic        wb_access;
    logic        wr_lane0;
    logic [1:0]  reg_sel;
    logic        wr_ctrl;
    logic        wr_req;
    logic        wr_status;
    logic        rd_result;
    logic        flush;
    logic        fsm_start;
    logic [31:0] rd_data;

    logic        req_pop;
    logic [7:0]  req_dout;
    logic [CW-1:0] req_count;
    logic        req_full;
    logic        req_empty;

    logic        res_push;
    result_t     res_din;
    result_t     res_dout;
    logic [CW-1:0] res_count;
    logic        res_full;
    logic        res_empty;

    logic        unused_bits;

    // A new access is taken only while ack is low, so a held strobe costs two cycles.
    assign addr_hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wb_access = wbs_cyc_i & wbs_stb_i & addr_hit & ~wbs_ack_o;
    assign wr_lane0  = wb_access & wbs_we_i & wbs_sel_i[0];
    assign reg_sel   = wbs_adr_i[3:2];
    assign wr_ctrl   = wr_lane0 & (reg_sel == REG_CTRL);
    assign wr_req    = wr_lane0 & (reg_sel == REG_REQ);
    assign wr_status = wr_lane0 & (reg_sel == REG_STATUS);
    assign rd_result = wb_access & ~wbs_we_i & (reg_sel == REG_RESULT);
    assign flush     = wr_ctrl & wbs_dat_i[CTRL_FLUSH];

    assign fsm_start = (state == ST_IDLE) & enable & ~req_empty & ~res_full & ~flush;
    assign req_pop   = fsm_start;
    assign res_push  = (state == ST_CAPTURE) & ~flush;
    assign res_din   = {enc_gs, enc_eno, enc_code};

    assign unused_bits = ^{wbs_dat_i, wbs_sel_i, wbs_adr_i[1:0]};

    prio_enc_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .flush (flush),
        .push  (wr_req),
        .pop   (req_pop),
        .din   (wbs_dat_i[7:0]),
        .dout  (req_dout),
        .count (req_count),
        .full  (req_full),
        .empty (req_empty)
    );

    prio_enc_fifo #(.WIDTH($bits(result_t)), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .flush (flush),
        .push  (res_push),
        .pop   (rd_result),
        .din   (res_din),
        .dout  (res_dout),
        .count (res_count),
        .full  (res_full),
        .empty (res_empty)
    );

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_ENABLE] = enable;
                rd_data[CTRL_IRQ_EN] = irq_en;
            end
            REG_RESULT: begin
                if (!res_empty) begin
                    rd_data[RES_VALID] = 1'b1;
                    rd_data[RES_GS]    = res_dout.gs;
                    rd_data[RES_ENO]   = res_dout.eno;
                    rd_data[2:0]       = res_dout.code;
                end
            end
            REG_STATUS: begin
                rd_data[3:0]       = 4'(req_count);
                rd_data[7:4]       = 4'(res_count);
                rd_data[STAT_OVF]  = ovf;
                rd_data[STAT_BUSY] = (state != ST_IDLE);
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            enable    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            wbs_ack_o <= wb_access;
            wbs_dat_o <= (wb_access && !wbs_we_i) ? rd_data : '0;
            if (wr_ctrl) enable <= wbs_dat_i[CTRL_ENABLE];
            // A push into a full queue survives only if the sequencer pops that same cycle.
            if (wr_req && req_full && !req_pop)
                ovf <= 1'b1;
            else if (wr_status && wbs_dat_i[STAT_OVF])
                ovf <= 1'b0;
        end
    end

`ifdef PRIO_ENC_IRQ_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            irq_o <= irq_en & (res_count != '0);
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    // Sequencer: pop and present one request, hold ENC_WAIT cycles, then capture.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            enc_in   <= '0;
            enc_en   <= 1'b0;
        end else if (flush) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            enc_en   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fsm_start) begin
                        state    <= ST_DRIVE;
                        enc_in   <= req_dout;
                        enc_en   <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (wait_cnt == 3'(ENC_WAIT - 1))
                        state <= ST_CAPTURE;
                    else
                        wait_cnt <= wait_cnt + 3'd1;
                end
                ST_CAPTURE: begin
                    state  <= ST_IDLE;
                    enc_en <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    enc_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_prio_enc_ctrl.sv
// Directed bench for wb_prio_enc_ctrl with a behavioural 8-to-3 priority encoder attached.
// The interrupt scenario follows PRIO_ENC_IRQ_EN the same way the design does.
module tb_wb_prio_enc_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  enc_in;
    logic        enc_en;
    logic [2:0]  enc_code;
    logic        enc_gs;
    logic        enc_eno;
    logic        irq;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    wb_prio_enc_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .ENC_WAIT(1)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .enc_in    (enc_in),
        .enc_en    (enc_en),
        .enc_code  (enc_code),
        .enc_gs    (enc_gs),
        .enc_eno   (enc_eno),
        .irq_o     (irq)
    );

    // Highest set bit wins; gs flags any input, eno flags enabled-but-idle.
    always_comb begin
        enc_code = 3'd0;
        for (int b = 0; b < 8; b++)
            if (enc_in[b]) enc_code = 3'(b);
        if (!enc_en) enc_code = 3'd0;
        enc_gs  = enc_en & (|enc_in);
        enc_eno = enc_en & ~(|enc_in);
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, output bit acked);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = a; wdat = d;
        acked = 1'b0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) acked = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        bit acked;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = a;
        acked = 1'b0;
        d = 32'hDEAD_BEEF;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                d = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_read(a, v);
        total++;
        if (v !== exp) $display("FAIL %s: got 0x%08h want 0x%08h", name, v, exp);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ack, rdat, enc_in, enc_en, irq} !== 43'd0)
            $display("FAIL reset_outputs: got ack=%b dat=0x%08h in=0x%02h en=%b irq=%b want all 0",
                     ack, rdat, enc_in, enc_en, irq);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        expect_rd("reset_status", BASE + 32'hC, 32'h0);
        expect_rd("reset_ctrl", BASE + 32'h0, 32'h0);
    endtask

    task automatic test_basic();
        bit acked;
        int en_cycles;
        logic [7:0] seen_in;
        wb_write(BASE + 32'h0, 32'h1, acked);
        wb_write(BASE + 32'h4, 32'h90, acked);
        en_cycles = 0;
        seen_in = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (enc_en) begin
                en_cycles++;
                seen_in = enc_in;
            end
        end
        total++;
        if (en_cycles !== 2) $display("FAIL enc_en_width: got %0d want 2", en_cycles);
        else passed++;
        total++;
        if (seen_in !== 8'h90) $display("FAIL enc_in_drive: got 0x%02h want 0x90", seen_in);
        else passed++;
        expect_rd("result_0x90", BASE + 32'h8, 32'h8000_0207);
        wb_write(BASE + 32'h4, 32'h00, acked);
        repeat (6) @(posedge clk);
        expect_rd("result_0x00", BASE + 32'h8, 32'h8000_0100);
        wb_write(BASE + 32'h4, 32'h0C, acked);
        repeat (6) @(posedge clk);
        expect_rd("result_0x0c", BASE + 32'h8, 32'h8000_0203);
    endtask

    task automatic test_overflow();
        bit acked;
        wb_write(BASE + 32'h0, 32'h0, acked);
        for (int i = 0; i < 5; i++) wb_write(BASE + 32'h4, 32'(8'h11 * (i + 1)), acked);
        expect_rd("ovf_status", BASE + 32'hC, 32'h104);
        wb_write(BASE + 32'hC, 32'h100, acked);
        expect_rd("ovf_w1c", BASE + 32'hC, 32'h004);
        wb_write(BASE + 32'h0, 32'h2, acked);
        expect_rd("flush_idle_status", BASE + 32'hC, 32'h000);
        expect_rd("flush_reads_zero", BASE + 32'h0, 32'h0);
    endtask

    task automatic test_empty_and_decode();
        bit acked;
        expect_rd("empty_result", BASE + 32'h8, 32'h0);
        expect_rd("empty_counts", BASE + 32'hC, 32'h0);
        wb_write(BASE + 32'h10, 32'h1, acked);
        total++;
        if (acked !== 1'b0) $display("FAIL off_map_ack: got %b want 0", acked);
        else passed++;
        wb_write(BASE + 32'h14, 32'h55, acked);
        total++;
        if (acked !== 1'b0) $display("FAIL off_map_req_ack: got %b want 0", acked);
        else passed++;
        expect_rd("off_map_no_effect", BASE + 32'hC, 32'h0);
        expect_rd("off_map_ctrl", BASE + 32'h0, 32'h0);
    endtask

    task automatic test_flush_mid_drive();
        bit acked;
        bit found;
        wb_write(BASE + 32'h4, 32'h01, acked);
        wb_write(BASE + 32'h4, 32'h02, acked);
        wb_write(BASE + 32'h4, 32'h04, acked);
        wb_write(BASE + 32'h0, 32'h1, acked);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (enc_en) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        total++;
        if (!found) $display("FAIL flush_drive_start: got enc_en=%b want 1", enc_en);
        else passed++;
        wb_write(BASE + 32'h0, 32'h3, acked);
        total++;
        if (enc_en !== 1'b0) $display("FAIL flush_enc_en: got %b want 0", enc_en);
        else passed++;
        expect_rd("flush_status", BASE + 32'hC, 32'h000);
        repeat (6) @(posedge clk);
        expect_rd("flush_no_result", BASE + 32'hC, 32'h000);
        expect_rd("flush_ctrl_keeps_enable", BASE + 32'h0, 32'h1);
        wb_write(BASE + 32'h0, 32'h0, acked);
    endtask

    task automatic test_back_to_back();
        bit acked;
        wb_write(BASE + 32'h0, 32'h1, acked);
        wb_write(BASE + 32'h4, 32'h81, acked);
        wb_write(BASE + 32'h4, 32'h06, acked);
        wb_write(BASE + 32'h4, 32'h01, acked);
        repeat (20) @(posedge clk);
        expect_rd("b2b_status", BASE + 32'hC, 32'h030);
        expect_rd("b2b_res0", BASE + 32'h8, 32'h8000_0207);
        expect_rd("b2b_res1", BASE + 32'h8, 32'h8000_0202);
        expect_rd("b2b_res2", BASE + 32'h8, 32'h8000_0200);
        expect_rd("b2b_drained", BASE + 32'hC, 32'h000);
    endtask

    task automatic test_irq();
        bit acked;
        int rise_at;
        logic [31:0] v;
        wb_write(BASE + 32'h0, 32'h5, acked);
        wb_write(BASE + 32'h4, 32'h01, acked);
        rise_at = 0;
        for (int i = 1; i <= 10 && rise_at == 0; i++) begin
            @(posedge clk); #1;
            if (irq) rise_at = i;
        end
`ifdef PRIO_ENC_IRQ_EN
        // Pop on cycle 1, push on cycle 3, registered irq on cycle 4.
        total++;
        if (rise_at !== 4) $display("FAIL irq_rise: got cycle %0d want 4", rise_at);
        else passed++;
        expect_rd("irq_ctrl", BASE + 32'h0, 32'h5);
        wb_read(BASE + 32'h8, v);
        total++;
        if (v !== 32'h8000_0200 || irq !== 1'b1)
            $display("FAIL irq_read: got dat=0x%08h irq=%b want 0x80000200 irq=1", v, irq);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (irq !== 1'b0) $display("FAIL irq_fall: got %b want 0", irq);
        else passed++;
`else
        total++;
        if (rise_at !== 0) $display("FAIL irq_tied_low: rose on cycle %0d want never", rise_at);
        else passed++;
        expect_rd("irq_ctrl_bit2_absent", BASE + 32'h0, 32'h1);
        wb_read(BASE + 32'h8, v);
        total++;
        if (v !== 32'h8000_0200) $display("FAIL irq_result: got 0x%08h want 0x80000200", v);
        else passed++;
`endif
    endtask

    task automatic test_async_reset();
        bit acked;
        bit found;
        wb_write(BASE + 32'h4, 32'h01, acked);
        repeat (6) @(posedge clk);
        wb_write(BASE + 32'h4, 32'h90, acked);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (enc_en) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        total++;
        if (!found) $display("FAIL rst_drive_start: got enc_en=%b want 1", enc_en);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({enc_en, irq, enc_in, ack} !== 11'd0)
            $display("FAIL async_reset: got en=%b irq=%b in=0x%02h ack=%b want all 0",
                     enc_en, irq, enc_in, ack);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
        expect_rd("post_reset_status", BASE + 32'hC, 32'h0);
        expect_rd("post_reset_ctrl", BASE + 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_empty_and_decode();
        test_flush_mid_drive();
        test_back_to_back();
        test_irq();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_prio_enc_ctrl.md
# wb_prio_enc_ctrl

Wishbone classic slave that sits directly upstream of the 8-to-3 priority encoder (`user_proj_example`) inside `user_project_wrapper`. It queues request vectors written by the management SoC and presents them one at a time to the encoder. It samples each encoder result (`io_out`, `gs`, `eno`) into a result queue that software reads back. It also reports queue status, and an optional interrupt signals that results are waiting.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000: register block base; bits [31:4] are decoded.
- `FIFO_DEPTH`, 4: entries per queue; must be a power of two, at least 2.
- `ENC_WAIT`, 1: cycles the encoder input is held stable before the result is sampled, range 1–7.

Ports:
- `wb_clk_i`, in, 1: the single clock.
- `wb_rst_ni`, in, 1: asynchronous active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`, in, 1 each: Wishbone classic controls.
- `wbs_sel_i`, in, 4: byte lanes; only lane 0 is honoured for writes.
- `wbs_adr_i`, in, 32: byte address.
- `wbs_dat_i`, in, 32: write data.
- `wbs_ack_o`, out, 1: transfer acknowledge.
- `wbs_dat_o`, out, 32: read data.
- `enc_in`, out, 8: drives encoder `io_in`.
- `enc_en`, out, 1: drives encoder `io_en`.
- `enc_code`, in, 3: from encoder `io_out`.
- `enc_gs`, `enc_eno`, in, 1 each: from encoder `gs` / `eno`.
- `irq_o`, out, 1: result-available interrupt.

## Operation
- Register map (offsets from `BASE_ADDR`, selected by `wbs_adr_i[3:2]`):
  - 0x0 CTRL (R/W):
    - bit0 `enable`.
    - bit1 `flush`: write-1, self-clears, reads 0.
    - bit2 `irq_en`.
  - 0x4 REQ (W): pushes `wbs_dat_i[7:0]`. Reads return 0.
  - 0x8 RESULT (R): pops one entry and returns:
    - [2:0] `code`, [8] `eno`, [9] `gs`, [31] `valid`.
    - If the queue is empty: returns 0 (valid=0) and does not pop. Writes are ignored.
  - 0xC STATUS:
    - [3:0] request count, [7:4] result count.
    - [8] `ovf`: sticky, write-1-to-clear.
    - [9] `busy`: FSM not in IDLE.
- Address not matching `BASE_ADDR[31:4]`: no ack, no side effects.
- A REQ write while the request queue is full drops the data and sets `ovf`.
- Sequencer FSM:
  - IDLE → DRIVE when `enable` is set, the request queue is non-empty and the result queue is not full. On that transition it pops the request and loads `enc_in`.
  - DRIVE counts `ENC_WAIT` cycles, then moves to CAPTURE.
  - CAPTURE pushes {`gs`, `eno`, `code`} into the result queue, then returns to IDLE.
- `enc_en` is 1 only in DRIVE and CAPTURE. `enc_in` holds its last value otherwise.
- Clearing `enable` mid-operation lets the current item finish; no new pop occurs.
- Flush empties both queues and forces the FSM to IDLE in the same cycle. Any in-flight item is discarded. `ovf` is unaffected.
- A REQ push and an FSM pop of the request queue in the same cycle are both honoured; the count is unchanged. The same applies to an FSM push and a RESULT pop on the result queue.

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `enc_in`=0, `enc_en`=0, `irq_o`=0. CTRL=0, queues empty, `ovf`=0, FSM in IDLE.
- Reset is asynchronous at any point, including mid-transfer; the state returns to the reset values immediately.
- Ack:
  - `wbs_ack_o` pulses for exactly one cycle, in the cycle after `cyc&stb` is first seen.
  - It is 0 in the following cycle even if `stb` stays high, so each access completes in 2 cycles.
  - Register side effects (push, pop, W1C, CTRL update) happen on the ack edge.
- Read data is registered and valid while `wbs_ack_o`=1; it is 0 otherwise.
- Per-item latency, from the pop edge to the result count incrementing: `ENC_WAIT`+1 cycles. With `ENC_WAIT`=1 that is 2 cycles, and sustained throughput is one item every 3 cycles.
- `irq_o` is registered and updates one cycle after the result count or CTRL changes.

## Configuration
- `PRIO_ENC_IRQ_EN` defined: `irq_o` = `irq_en` AND (result count ≠ 0).
- `PRIO_ENC_IRQ_EN` undefined:
  - `irq_o` is tied to 0.
  - CTRL bit2 is not implemented and reads 0.

## Structure
- Package `wb_prio_enc_pkg` holds:
  - the register offset constants and CTRL/STATUS bit indices;
  - the FSM state enum (IDLE, DRIVE, CAPTURE);
  - the packed result struct {gs, eno, code}.
- Sub-module `prio_enc_fifo` is a parameterised synchronous FIFO with push, pop, flush, count, full and empty.
  - It is instantiated twice: the request queue (8-bit entries) and the result queue (5-bit entries).

## Test plan
- Write CTRL=1, then REQ=0x90. Read RESULT → 0x8000_0207 (valid, gs=1, eno=0, code=7). `enc_en` is high for 2 cycles.
- REQ=0x00 with enable set. Read RESULT → 0x8000_0100 (gs=0, eno=1, code=0).
- With `enable`=0, write REQ five times (FIFO_DEPTH=4).
  - STATUS → 0x104 (count 4, ovf=1).
  - Write STATUS bit8 → `ovf` clears.
- Read RESULT on an empty queue → 0x0000_0000 and the counts are unchanged. An access with the address at `BASE_ADDR`+0x10 gets no ack.
- Queue 3 requests, then write CTRL=0x3 during the first DRIVE.
  - STATUS → 0x000 with `busy`=0 on the next read.
  - No result is pushed.
- With `PRIO_ENC_IRQ_EN` defined and CTRL=0x5, push REQ=0x01.
  - `irq_o` rises 1 cycle after the result count becomes 1.
  - `irq_o` falls 1 cycle after the RESULT read.
- Assert `wb_rst_ni` low mid-DRIVE → `enc_en`, `irq_o` and the counts are 0 immediately.
